dm_access_ctrl: RTL and testbench

Data-memory access controller for the EX/DM stage of the 16-bit pipeline. Converts the EX_DM load/store request into a registered req/gnt/rvalid transaction on the data-memory port. Stalls the pipeline until the transaction completes, then presents the captured load data on `dm_rd_data_EX_DM` for the writeback-select register directly downstream.

---
 rtl/dm_access_ctrl_pkg.sv | 14 +
 rtl/dm_access_ctrl_wdog.sv | 31 +++
 rtl/dm_access_ctrl.sv | 111 +++++++++++
 tb/tb_dm_access_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and constants for the EX/DM data-memory access controller.
package dm_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } dm_state_e;

  localparam logic [15:0]  DM_ERR_DATA         = 16'hFFFF;
  localparam int unsigned  DM_TIMEOUT_CYC_DEF  = 255;

endpackage

// File: rtl/dm_access_ctrl_wdog.sv
// Clearable timeout counter: counts enabled cycles and flags the LIMIT-th one.
module dm_wdog
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = DM_TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign tc_c = en & (cnt == CNT_W'(LIMIT - 1));

  // Saturates at the terminal value until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// EX/DM data-memory access controller: req/gnt/rvalid handshake with pipeline stall.
// Optional access watchdog enabled by defining DM_TIMEOUT_EN.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = DM_TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_re_EX_DM,
  input  logic              dm_we_EX_DM,
  input  logic [ADDR_W-1:0] addr_EX_DM,
  input  logic [DATA_W-1:0] wdata_EX_DM,
  output logic              stall_DM,
  output logic [DATA_W-1:0] dm_rd_data_EX_DM,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  dm_state_e state;
  logic      access;
  logic      tmo_c;

  assign access   = dm_re_EX_DM | dm_we_EX_DM;
  assign stall_DM = access & (state != DONE);

`ifdef DM_TIMEOUT_EN
  logic wdog_clr;
  logic wdog_en;

  assign wdog_clr = (state == IDLE) & access;
  assign wdog_en  = (state == REQ) | (state == WAIT);

  dm_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wdog_clr),
    .en   (wdog_en),
    .tc_c (tmo_c)
  );
`else
  assign tmo_c = 1'b0;
`endif

  // Transaction FSM; a real response always wins over a same-cycle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      dm_rd_data_EX_DM <= '0;
      dm_err           <= 1'b0;
    end else begin
      dm_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            mem_addr  <= addr_EX_DM;
            mem_wdata <= wdata_EX_DM;
            mem_we    <= ~dm_re_EX_DM;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= DONE;
            end else if (mem_rvalid) begin
              dm_rd_data_EX_DM <= mem_rdata;
              state            <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (tmo_c) begin
            mem_req <= 1'b0;
            dm_err  <= 1'b1;
            if (!mem_we) dm_rd_data_EX_DM <= DATA_W'(DM_ERR_DATA);
            state   <= DONE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            dm_rd_data_EX_DM <= mem_rdata;
            state            <= DONE;
          end else if (tmo_c) begin
            dm_err           <= 1'b1;
            dm_rd_data_EX_DM <= DATA_W'(DM_ERR_DATA);
            state            <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: transaction-timeline model plus per-cycle compare.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_re, dm_we;
  logic [15:0] addr, wdata;
  logic        stall;
  logic [15:0] rd_data;
  logic        err;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  dm_access_ctrl #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dm_re_EX_DM      (dm_re),
    .dm_we_EX_DM      (dm_we),
    .addr_EX_DM       (addr),
    .wdata_EX_DM      (wdata),
    .stall_DM         (stall),
    .dm_rd_data_EX_DM (rd_data),
    .dm_err           (err),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model state: what the memory port and load-data register must hold.
  logic        m_we;
  logic [15:0] m_addr, m_wdata, m_rd;
  logic        e_stall, e_req, e_err, chk;

  int       obs_stall, obs_req;
  logic [7:0] stall_hist;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("stall_DM", 16'(stall), 16'(e_stall));
      check("mem_req", 16'(mem_req), 16'(e_req));
      check("mem_we", 16'(mem_we), 16'(m_we));
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("rd_data", rd_data, m_rd);
      check("dm_err", 16'(err), 16'(e_err));
      if (stall === 1'b1) obs_stall++;
      if (mem_req === 1'b1) obs_req++;
      stall_hist = {stall_hist[6:0], stall};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0;
  endtask

  // No access presented; optional stray gnt/rvalid that must be ignored.
  task automatic idle(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      dm_re = 1'b0; dm_we = 1'b0;
      mem_gnt = noise; mem_rvalid = noise; mem_rdata = noise ? 16'hDEAD : 16'h0;
      e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0;
      step();
    end
  endtask

  // One access: IDLE cycle, g+1 REQ cycles, r WAIT cycles (loads), then DONE.
  task automatic do_access(input logic re, input logic we, input logic [15:0] a,
                           input logic [15:0] wd, input int g, input int r,
                           input logic [15:0] rdat, input bit noise);
    int rr;
    int len;
    rr  = re ? r : 0;
    len = g + rr + 3;
    obs_stall = 0; obs_req = 0;
    for (int k = 0; k < len; k++) begin
      dm_re = re; dm_we = we; addr = a; wdata = wd;
      mem_gnt    = (k == g + 1);
      mem_rvalid = re && (k == g + 1 + rr);
      mem_rdata  = mem_rvalid ? rdat : 16'h0;
      if (noise) begin
        if (k == 0 || k == len - 1) begin
          mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        end
        if (re && k >= 1 && k < g + 1) begin
          mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        end
      end
      if (k == 1) begin
        m_addr = a; m_wdata = wd; m_we = !re;
      end
      if (re && k == len - 1) m_rd = rdat;
      e_stall = (k < len - 1);
      e_req   = (k >= 1 && k <= g + 1);
      e_err   = 1'b0;
      step();
    end
  endtask

  // Load granted in its first REQ cycle with no data; reset lands in cycle n.
  task automatic reset_mid(input int n, input logic [15:0] a);
    for (int k = 0; k < n; k++) begin
      dm_re = 1'b1; dm_we = 1'b0; addr = a; wdata = 16'h0;
      mem_gnt = (k == 1); mem_rvalid = 1'b0; mem_rdata = 16'h0;
      if (k == 1) begin
        m_addr = a; m_wdata = 16'h0; m_we = 1'b0;
      end
      e_stall = 1'b1; e_req = (k == 1); e_err = 1'b0;
      step();
    end
    rst = 1'b1;
    mem_gnt = 1'b0;
    model_reset();
    e_stall = 1'b1; e_req = 1'b0;
    step();
    rst = 1'b0;
    dm_re = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
    e_stall = 1'b0;
    step();
    idle(1, 1'b0);
  endtask

  initial begin
    chk = 1'b0;
    rst = 1'b1;
    dm_re = 1'b0; dm_we = 1'b0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_reset();
    e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0;
    stall_hist = '0; obs_stall = 0; obs_req = 0;
    step();
    chk = 1'b1;
    idle(2, 1'b0);
    // Stall follows access while reset is held.
    dm_re = 1'b1; e_stall = 1'b1;
    step();
    dm_re = 1'b0; e_stall = 1'b0;
    step();
    rst = 1'b0;
    idle(2, 1'b1);

    // Minimal load.
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 0, 16'hBEEF, 1'b0);
    check("t1_stall_cycles", 16'(obs_stall), 16'd2);
    check("t1_rd_data", rd_data, 16'hBEEF);

    // Store, grant delayed 3 cycles.
    idle(1, 1'b1);
    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 3, 0, 16'h0000, 1'b0);
    check("t2_req_cycles", 16'(obs_req), 16'd4);
    check("t2_stall_cycles", 16'(obs_stall), 16'd5);
    check("t2_rd_unchanged", rd_data, 16'hBEEF);

    // Load through two WAIT cycles.
    idle(1, 1'b0);
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 2, 16'h00A5, 1'b0);
    check("t3_stall_cycles", 16'(obs_stall), 16'd4);
    check("t3_rd_data", rd_data, 16'h00A5);

    // Store then load back-to-back.
    stall_hist = '0;
    do_access(1'b0, 1'b1, 16'h0030, 16'h55AA, 0, 0, 16'h0000, 1'b0);
    do_access(1'b1, 1'b0, 16'h0030, 16'h0000, 0, 0, 16'h55AA, 1'b0);
    check("t4_stall_pattern", 16'(stall_hist[5:0]), 16'h0036);
    check("t4_rd_data", rd_data, 16'h55AA);

    // re and we together is a load; stray handshakes outside REQ/WAIT ignored.
    do_access(1'b1, 1'b1, 16'h0050, 16'hFFFF, 1, 1, 16'h1357, 1'b1);
    check("t5_rd_data", rd_data, 16'h1357);

    // Reset in WAIT, then late rvalid.
    reset_mid(2, 16'h0077);
    check("t6_rd_after_rst", rd_data, 16'h0000);
    check("t6_req_after_rst", 16'(mem_req), 16'h0000);

    // Reset while the request is still pending.
    do_access(1'b1, 1'b0, 16'h0060, 16'h0000, 2, 0, 16'hC0DE, 1'b0);
    reset_mid(1, 16'h0088);
    check("t7_rd_after_rst", rd_data, 16'h0000);
    do_access(1'b0, 1'b1, 16'h0070, 16'hA5A5, 0, 0, 16'h0000, 1'b0);

`ifdef DM_TIMEOUT_EN
    // Load never granted: 8 REQ cycles, then DONE with error data.
    obs_req = 0;
    for (int k = 0; k < 10; k++) begin
      dm_re = 1'b1; dm_we = 1'b0; addr = 16'h0099; wdata = 16'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
      if (k == 1) begin
        m_addr = 16'h0099; m_wdata = 16'h0; m_we = 1'b0;
      end
      if (k == 9) m_rd = 16'hFFFF;
      e_stall = (k < 9); e_req = (k >= 1 && k <= 8); e_err = (k == 9);
      step();
    end
    check("t8_req_cycles", 16'(obs_req), 16'd8);
    check("t8_rd_data", rd_data, 16'hFFFF);
`endif

    idle(2, 1'b0);
    chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
